multiplicador_segmentado: RTL

MULTIPLICADOR_SEGMENTADO -- requirements
Module: multiplicador_segmentado

---
 rtl/multiplicador_segmentado.sv | 76 +++++++
 1 files changed

// File: rtl/multiplicador_segmentado.sv
// multiplicador_segmentado: pipelined shift-add reconstruction Num = Coc*Den + Res, one op per cycle.
module multiplicador_segmentado #(
    parameter int tamanyo = 8
) (
    input  logic                               CLK,
    input  logic                               RSTa,
    input  logic                               START,
    input  logic [tamanyo-1:0]                 Coc,
    input  logic [tamanyo-1:0]                 Den,
    input  logic [tamanyo-1:0]                 Res,
    output logic [2*tamanyo-1:0]               Num,
    output logic                               Done,
    output logic                               ERR,
    output logic [$clog2(tamanyo+1)-1:0]       OCUP
);
    localparam int W  = 2*tamanyo;
    localparam int OW = $clog2(tamanyo+1);
    logic [W-1:0]       acc_q [tamanyo];
    logic [W-1:0]       acc_d [tamanyo];
    logic [tamanyo-1:0] coc_q [tamanyo];
    logic [tamanyo-1:0] coc_d [tamanyo];
    logic [tamanyo-1:0] den_q [tamanyo];
    logic [tamanyo-1:0] den_d [tamanyo];
    logic [tamanyo-1:0] err_q, err_d;
    logic [tamanyo-1:0] vld_q, vld_d;
    logic [OW-1:0]      ocup_q, ocup_d;
    logic               done;
    assign done = vld_q[tamanyo-1];
    always_comb begin
        acc_d = acc_q;
        coc_d = coc_q;
        den_d = den_q;
        err_d = err_q;
        vld_d = {vld_q[tamanyo-2:0], START};
        if (START) begin
            acc_d[0] = W'(Res) + (Coc[0] ? W'(Den) : '0);
            coc_d[0] = Coc;
            den_d[0] = Den;
            err_d[0] = Res >= Den;
        end
        // stage j adds the j-th partial product, Den shifted left by j
        for (int j = 1; j < tamanyo; j++) begin
            if (vld_q[j-1]) begin
                acc_d[j] = acc_q[j-1] + (coc_q[j-1][j] ? W'(den_q[j-1]) << j : '0);
                coc_d[j] = coc_q[j-1];
                den_d[j] = den_q[j-1];
                err_d[j] = err_q[j-1];
            end
        end
        ocup_d = (START && !done) ? ocup_q + OW'(1) :
                 (!START && done) ? ocup_q - OW'(1) : ocup_q;
    end
    always_ff @(posedge CLK or posedge RSTa) begin
        if (RSTa) begin
            for (int j = 0; j < tamanyo; j++) begin
                acc_q[j] <= '0;
                coc_q[j] <= '0;
                den_q[j] <= '0;
            end
            err_q  <= '0;
            vld_q  <= '0;
            ocup_q <= '0;
        end else begin
            acc_q  <= acc_d;
            coc_q  <= coc_d;
            den_q  <= den_d;
            err_q  <= err_d;
            vld_q  <= vld_d;
            ocup_q <= ocup_d;
        end
    end
    assign Num  = acc_q[tamanyo-1];
    assign ERR  = err_q[tamanyo-1];
    assign Done = done;
    assign OCUP = ocup_q;
endmodule
